axil_protocol_monitor: RTL

- Passive, parametrised AXI4-Lite protocol monitor. Taps all five channels of one master/slave link and drives no AXI signal.
- Tracks outstanding transactions and checks handshake stability, response ordering and timeouts.
- Reports sticky error flags, a first-error code and saturating transaction counters.
- Generalises the fixed 32/8 checker: any data/address width, configurable outstanding depth and timeout, runtime error clear.

---
 rtl/axil_protocol_monitor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axil_protocol_monitor.sv
// Passive AXI4-Lite link monitor: stability, ordering, overflow and timeout checks
// with sticky flags, a first-error code and saturating transaction counters.
module axil_protocol_monitor #(
    parameter int unsigned C_AXI_DATA_WIDTH  = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH  = 8,
    parameter int unsigned C_MAX_OUTSTANDING = 4,
    parameter int unsigned C_TIMEOUT         = 16,
    parameter int unsigned C_CNT_WIDTH       = 16
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESETN,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
    input  logic [2:0]                    AXI_ARPROT,
    input  logic                          AXI_ARVALID,
    input  logic                          AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]                    AXI_RRESP,
    input  logic                          AXI_RVALID,
    input  logic                          AXI_RREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    input  logic [2:0]                    AXI_AWPROT,
    input  logic                          AXI_AWVALID,
    input  logic                          AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
    input  logic                          AXI_WVALID,
    input  logic                          AXI_WREADY,
    input  logic [1:0]                    AXI_BRESP,
    input  logic                          AXI_BVALID,
    input  logic                          AXI_BREADY,
    input  logic                          err_clr,
    output logic [9:0]                    err_flags,
    output logic                          err_pulse,
    output logic [3:0]                    first_err_code,
    output logic [C_CNT_WIDTH-1:0]        rd_txn_cnt,
    output logic [C_CNT_WIDTH-1:0]        wr_txn_cnt,
    output logic [7:0]                    rd_pending,
    output logic [7:0]                    wr_pending
);

    localparam int unsigned AP_W = C_AXI_ADDR_WIDTH + 3;
    localparam int unsigned WP_W = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH / 8;
    localparam int unsigned RP_W = C_AXI_DATA_WIDTH + 2;
    localparam logic [7:0]  MAX_PEND = 8'(C_MAX_OUTSTANDING);
    localparam logic [15:0] TO_LAST  = 16'(C_TIMEOUT - 1);
    localparam logic [15:0] TO_HOLD  = 16'(C_TIMEOUT);

    // Channel index order matches error bits 0..4: AR, AW, W, R, B.
    logic [4:0] valid, ready, hs, unstable, stall, hs_fire;
    logic [AP_W-1:0] ar_pl, aw_pl;
    logic [WP_W-1:0] w_pl;
    logic [RP_W-1:0] r_pl;

    logic [4:0]      prev_valid_q, prev_ready_q;
    logic [AP_W-1:0] prev_ar_q, prev_aw_q;
    logic [WP_W-1:0] prev_w_q;
    logic [RP_W-1:0] prev_r_q;
    logic [1:0]      prev_b_q;
    logic            armed_q;

    logic [7:0]  rd_pend_q, aw_pend_q, w_pend_q;
    logic [8:0]  rd_step, aw_step, w_step;
    logic [4:0][15:0] hs_tmr_q, hs_tmr_d;
    logic [15:0] rto_tmr_q, rto_tmr_d, wto_tmr_q, wto_tmr_d;
    logic        rto_run, wto_run, rto_fire, wto_fire;
    logic [C_CNT_WIDTH-1:0] rd_cnt_q, wr_cnt_q;

    logic [9:0] viol, flags_q, flags_d;
    logic [3:0] code_q, code_d, low_idx;
    logic       pulse_q;

    // Returns {overflow, next}; simultaneous +1/-1 holds, -1 never wraps below 0.
    function automatic logic [8:0] pend_step(input logic [7:0] cnt, input logic inc,
                                             input logic dec);
        logic [8:0] r;
        r = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt >= MAX_PEND) r[8] = 1'b1;
            else                 r[7:0] = cnt + 8'd1;
        end else if (dec && !inc && cnt != '0) begin
            r[7:0] = cnt - 8'd1;
        end
        return r;
    endfunction

    assign valid = {AXI_BVALID, AXI_RVALID, AXI_WVALID, AXI_AWVALID, AXI_ARVALID};
    assign ready = {AXI_BREADY, AXI_RREADY, AXI_WREADY, AXI_AWREADY, AXI_ARREADY};
    assign hs    = valid & ready;
    assign stall = valid & ~ready;
    assign ar_pl = {AXI_ARADDR, AXI_ARPROT};
    assign aw_pl = {AXI_AWADDR, AXI_AWPROT};
    assign w_pl  = {AXI_WDATA, AXI_WSTRB};
    assign r_pl  = {AXI_RDATA, AXI_RRESP};

    always_comb begin
        unstable = '0;
        unstable[0] = !valid[0] || (ar_pl != prev_ar_q);
        unstable[1] = !valid[1] || (aw_pl != prev_aw_q);
        unstable[2] = !valid[2] || (w_pl != prev_w_q);
        unstable[3] = !valid[3] || (r_pl != prev_r_q);
        unstable[4] = !valid[4] || (AXI_BRESP != prev_b_q);
        unstable = unstable & prev_valid_q & ~prev_ready_q;
    end

    assign rd_step = pend_step(rd_pend_q, hs[0], hs[3]);
    assign aw_step = pend_step(aw_pend_q, hs[1], hs[4]);
    assign w_step  = pend_step(w_pend_q,  hs[2], hs[4]);

    // Timers saturate one past the firing value so each timeout fires once per run.
    always_comb begin
        hs_tmr_d = '0;
        hs_fire  = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (stall[i]) begin
                hs_fire[i]  = (hs_tmr_q[i] == TO_LAST);
                hs_tmr_d[i] = (hs_tmr_q[i] == TO_HOLD) ? hs_tmr_q[i] : hs_tmr_q[i] + 16'd1;
            end
        end
    end

    assign rto_run   = (rd_pend_q != '0) && !AXI_RVALID;
    assign wto_run   = (aw_pend_q != '0) && (w_pend_q != '0) && !AXI_BVALID;
    assign rto_fire  = rto_run && (rto_tmr_q == TO_LAST);
    assign wto_fire  = wto_run && (wto_tmr_q == TO_LAST);
    assign rto_tmr_d = !rto_run ? '0 : (rto_tmr_q == TO_HOLD) ? rto_tmr_q : rto_tmr_q + 16'd1;
    assign wto_tmr_d = !wto_run ? '0 : (wto_tmr_q == TO_HOLD) ? wto_tmr_q : wto_tmr_q + 16'd1;

    always_comb begin
        viol    = '0;
        viol[4:0] = unstable;
        viol[5] = AXI_RVALID && (rd_pend_q == '0);
        viol[6] = AXI_BVALID && ((aw_pend_q == '0) || (w_pend_q == '0));
        viol[7] = rd_step[8] | aw_step[8] | w_step[8];
        viol[8] = |hs_fire;
        viol[9] = rto_fire | wto_fire;
        if (!armed_q) viol = '0;
    end

    always_comb begin
        low_idx = 4'hF;
        for (int unsigned i = 0; i < 10; i++) begin
            if (viol[i] && low_idx == 4'hF) low_idx = 4'(i);
        end
    end

    // Clear is applied first, then new violations are merged so set wins.
    always_comb begin
        flags_d = (err_clr ? '0 : flags_q) | viol;
        code_d  = err_clr ? 4'hF : code_q;
        if (code_d == 4'hF) code_d = low_idx;
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            prev_valid_q <= '0;
            prev_ready_q <= '0;
            prev_ar_q    <= '0;
            prev_aw_q    <= '0;
            prev_w_q     <= '0;
            prev_r_q     <= '0;
            prev_b_q     <= '0;
            armed_q      <= 1'b0;
            rd_pend_q    <= '0;
            aw_pend_q    <= '0;
            w_pend_q     <= '0;
            hs_tmr_q     <= '0;
            rto_tmr_q    <= '0;
            wto_tmr_q    <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            flags_q      <= '0;
            code_q       <= 4'hF;
            pulse_q      <= 1'b0;
        end else begin
            prev_valid_q <= valid;
            prev_ready_q <= ready;
            prev_ar_q    <= ar_pl;
            prev_aw_q    <= aw_pl;
            prev_w_q     <= w_pl;
            prev_r_q     <= r_pl;
            prev_b_q     <= AXI_BRESP;
            armed_q      <= 1'b1;
            rd_pend_q    <= rd_step[7:0];
            aw_pend_q    <= aw_step[7:0];
            w_pend_q     <= w_step[7:0];
            hs_tmr_q     <= hs_tmr_d;
            rto_tmr_q    <= rto_tmr_d;
            wto_tmr_q    <= wto_tmr_d;
            if (hs[3] && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
            if (hs[4] && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
            flags_q      <= flags_d;
            code_q       <= code_d;
            pulse_q      <= |viol;
        end
    end

    assign err_flags      = flags_q;
    assign err_pulse      = pulse_q;
    assign first_err_code = code_q;
    assign rd_txn_cnt     = rd_cnt_q;
    assign wr_txn_cnt     = wr_cnt_q;
    assign rd_pending     = rd_pend_q;
    assign wr_pending     = (aw_pend_q < w_pend_q) ? aw_pend_q : w_pend_q;

endmodule
